// File: rtl/emulador_de_teclado.sv
// Matrix keypad emulator: presses one key on a 4x4 active-low matrix with
// modelled contact bounce, a programmable hold time and a release gap.
//
// state      | meaning
// IDLE       | contact open, waiting for a command
// BOUNCE_ON  | contact chatter on press, ends closed for even BOUNCE_P
// HOLD       | contact stably closed for the latched hold time
// BOUNCE_OFF | contact chatter on release, first cycle still closed
// GAP        | contact open, minimum release time before next command
module emulador_de_teclado #(
    parameter int BOUNCE_P = 8,
    parameter int GAP_P    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  lin_matriz,
    output logic [3:0]  col_matriz,
    input  logic [3:0]  cmd_key,
    input  logic [15:0] cmd_hold,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_ON,
        HOLD,
        BOUNCE_OFF,
        GAP
    } state_t;

    localparam logic [15:0] BOUNCE_LD = (BOUNCE_P > 0) ? 16'(BOUNCE_P - 1) : 16'd0;
    localparam logic [15:0] GAP_LD    = 16'(GAP_P - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] hold_q, hold_d;
    logic [3:0]  key_q, key_d;
    logic        done_q, done_d;
    logic        contact;
    logic [1:0]  row_sel, col_sel;
    logic        last;

    assign last = (cnt_q == 16'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            hold_q  <= 16'd0;
            key_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            key_q   <= key_d;
            done_q  <= done_d;
        end
    end

    // Counter holds (cycles remaining - 1); a state exits when it reads zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        key_d   = key_q;
        done_d  = 1'b0;
        contact = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    key_d  = cmd_key;
                    hold_d = (cmd_hold == 16'd0) ? 16'd0 : 16'(cmd_hold - 16'd1);
                    if (BOUNCE_P == 0) begin
                        state_d = HOLD;
                        cnt_d   = hold_d;
                    end else begin
                        state_d = BOUNCE_ON;
                        cnt_d   = BOUNCE_LD;
                    end
                end
            end
            BOUNCE_ON: begin
                // Cycle index parity is LD[0] ^ cnt[0]; closed on odd indices.
                contact = BOUNCE_LD[0] ^ cnt_q[0];
                if (last) begin
                    state_d = HOLD;
                    cnt_d   = hold_q;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            HOLD: begin
                contact = 1'b1;
                if (last) begin
                    if (BOUNCE_P == 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LD;
                    end else begin
                        state_d = BOUNCE_OFF;
                        cnt_d   = BOUNCE_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            BOUNCE_OFF: begin
                contact = ~(BOUNCE_LD[0] ^ cnt_q[0]);
                if (last) begin
                    state_d = GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            GAP: begin
                if (last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        row_sel = 2'd0;
        col_sel = 2'd0;
        case (key_q)
            4'h1: begin row_sel = 2'd0; col_sel = 2'd0; end
            4'h2: begin row_sel = 2'd0; col_sel = 2'd1; end
            4'h3: begin row_sel = 2'd0; col_sel = 2'd2; end
            4'hA: begin row_sel = 2'd0; col_sel = 2'd3; end
            4'h4: begin row_sel = 2'd1; col_sel = 2'd0; end
            4'h5: begin row_sel = 2'd1; col_sel = 2'd1; end
            4'h6: begin row_sel = 2'd1; col_sel = 2'd2; end
            4'hB: begin row_sel = 2'd1; col_sel = 2'd3; end
            4'h7: begin row_sel = 2'd2; col_sel = 2'd0; end
            4'h8: begin row_sel = 2'd2; col_sel = 2'd1; end
            4'h9: begin row_sel = 2'd2; col_sel = 2'd2; end
            4'hC: begin row_sel = 2'd2; col_sel = 2'd3; end
            4'hF: begin row_sel = 2'd3; col_sel = 2'd0; end
            4'h0: begin row_sel = 2'd3; col_sel = 2'd1; end
            4'hE: begin row_sel = 2'd3; col_sel = 2'd2; end
            default: begin row_sel = 2'd3; col_sel = 2'd3; end
        endcase
    end

    assign col_matriz = (contact && !lin_matriz[row_sel]) ? ~(4'b0001 << col_sel) : 4'b1111;
    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

endmodule

// File: doc/emulador_de_teclado.md
EMULADOR_DE_TECLADO -- requirements
Module: emulador_de_teclado

Interface
REQ-001 SHALL have parameter BOUNCE_P, default 8: contact-bounce length in clk cycles, applied on press and on release; 0 = no bounce.
REQ-002 SHALL have parameter GAP_P, default 4: minimum released (all-open) cycles after each key release before the next command is accepted; range 1..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 lin_matriz  input  4  row drive from the scanner, active-low; bit r = 0 means row r is driven.
REQ-006 col_matriz  output  4  column sense to the scanner, active-low; 4'b1111 = no contact.
REQ-007 cmd_key  input  4  hex key code to press.
REQ-008 cmd_hold  input  16  stable-press duration in cycles.
REQ-009 cmd_valid  input  1  command present.
REQ-010 cmd_ready  output  1  block can accept a command.
REQ-011 busy  output  1  a press sequence is in progress.
REQ-012 done  output  1  one-cycle pulse when a sequence completes.

Function
REQ-013 Key map (row, column) SHALL be: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = F,0,E,D; columns 0..3 left to right.
REQ-014 Column c SHALL be signalled as col_matriz bit c = 0 with all other bits 1 (col0 = 4'b1110, col3 = 4'b0111).
REQ-015 States SHALL be IDLE, BOUNCE_ON, HOLD, BOUNCE_OFF, GAP.
REQ-016 cmd_ready SHALL be 1 only in IDLE; busy SHALL be 1 in every state except IDLE.
REQ-017 Command accepted on the rising edge where cmd_valid = 1 and cmd_ready = 1; cmd_key and cmd_hold SHALL be latched on that edge; cmd_valid outside IDLE SHALL be ignored.
REQ-018 cmd_hold = 0 SHALL be treated as 1.
REQ-019 After acceptance: BOUNCE_ON for BOUNCE_P cycles, HOLD for the latched hold value, BOUNCE_OFF for BOUNCE_P cycles, GAP for GAP_P cycles, then IDLE.
REQ-020 BOUNCE_P = 0: BOUNCE_ON and BOUNCE_OFF SHALL be skipped (accept -> HOLD; HOLD end -> GAP).
REQ-021 One down-counter SHALL time each state, loaded on entry; the state exits in the cycle the counter reaches its last count.
REQ-022 Contact SHALL be closed in all HOLD cycles, open in IDLE and GAP.
REQ-023 In BOUNCE_ON, contact SHALL be closed on odd cycle indices (0-based from state entry), so the contact alternates and ends closed for even BOUNCE_P.
REQ-024 In BOUNCE_OFF, contact SHALL be closed on even cycle indices, so the first release cycle is still closed.
REQ-025 col_matriz SHALL be combinational from lin_matriz: when contact is closed and lin_matriz bit (latched row) = 0, the latched column bit SHALL be 0; otherwise col_matriz = 4'b1111.
REQ-026 Row drive on any other row SHALL NOT affect col_matriz (single-key matrix; no ghosting).
REQ-027 done SHALL be registered and equal 1 for exactly the first IDLE cycle after GAP; a command may be accepted in that same cycle.

Reset
REQ-028 rst = 0 SHALL force, asynchronously: state IDLE, counter 0, latched key 0, contact open, col_matriz = 4'b1111, cmd_ready = 1, busy = 0, done = 0.
REQ-029 Reset asserted mid-sequence SHALL abort the press with no done pulse; the first command after rst release SHALL be accepted normally.

Verification
REQ-030 BOUNCE_P = 0, key 5, hold 10, lin_matriz = 4'b1101 held -> col_matriz = 4'b1101 for exactly 10 cycles starting 1 cycle after accept; done 1 cycle after GAP_P further cycles.
REQ-031 Default params, key D, hold 20, lin_matriz = 4'b0111 -> col_matriz alternates 1111/0111 for 8 cycles, 0111 for 20, alternates 0111/1111 for 8, 1111 for 4; done high for one cycle; total busy = 40 cycles.
REQ-032 Key 0 held, lin_matriz cycles 1110 -> 1101 -> 1011 -> 0111 -> col_matriz = 4'b1101 only while lin_matriz = 0111; 1111 otherwise.
REQ-033 cmd_valid held high continuously, keys 1 then A -> second command accepted in the done cycle, not before; cmd_ready = 0 throughout each sequence.
REQ-034 cmd_hold = 0 -> exactly 1 HOLD cycle; rst pulsed low during HOLD -> col_matriz = 4'b1111 immediately, no done, next command accepted.
REQ-035 Closed-loop: drive the keypad decoder (DEBOUNCE_P = 5, active-high reset tied to !rst) with each of 16 keys, hold 200 -> decoder tecla_valid = 1 with tecla_value equal to the pressed key code.
